csm_arbiter: RTL and testbench

//  Owns the 4-entry shared memory (CSM) and arbitrates processor A and processor B ports onto it.

---
 rtl/csm_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_csm_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : csm_arbiter
// Brief    : Shared 4-entry memory with per-entry hold locks, round-robin
//            arbitration between processor ports A and B, optional hold timeout.
// Revision : 1.0
// ============================================================================
module csm_arbiter #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 8,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_req,
  input  logic [1:0]              a_op,
  input  logic [ADDR_W-1:0]       a_addr,
  input  logic [DATA_W-1:0]       a_wdata,
  output logic                    a_ack,
  output logic                    a_err,
  output logic [DATA_W-1:0]       a_rdata,
  input  logic                    b_req,
  input  logic [1:0]              b_op,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [DATA_W-1:0]       b_wdata,
  output logic                    b_ack,
  output logic                    b_err,
  output logic [DATA_W-1:0]       b_rdata,
  output logic [(2**ADDR_W)-1:0]  held_by_a,
  output logic [(2**ADDR_W)-1:0]  held_by_b,
  output logic                    busy
);
  localparam int NUM_ENTRIES = 2**ADDR_W;
  localparam int CNT_W       = $clog2(HOLD_TIMEOUT + 2);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_EXEC = 2'd1;
  localparam logic [1:0] C_ST_RESP = 2'd2;

  localparam logic [1:0] C_OP_READ  = 2'b00;
  localparam logic [1:0] C_OP_WRITE = 2'b01;
  localparam logic [1:0] C_OP_HOLD  = 2'b10;
  localparam logic [1:0] C_OP_REL   = 2'b11;

  logic [1:0]             r_state;
  logic                   r_rr_b;
  logic                   r_win_b;
  logic [1:0]             r_op;
  logic [ADDR_W-1:0]      r_addr;
  logic [DATA_W-1:0]      r_wdata;
  logic [DATA_W-1:0]      r_mem [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_held_a;
  logic [NUM_ENTRIES-1:0] r_held_b;
  logic [CNT_W-1:0]       r_cnt [NUM_ENTRIES];
  logic                   r_a_ack, r_a_err, r_b_ack, r_b_err;
  logic [DATA_W-1:0]      r_a_rdata, r_b_rdata;

  logic                   w_grant_b;
  logic                   w_exec;
  logic                   w_own_x;
  logic                   w_own_y;
  logic                   w_err;
  logic [DATA_W-1:0]      w_rdata;

  // X is the latched winner, Y the other port; ops are judged on the registered hold table
  always_comb begin
    w_grant_b = b_req && (!a_req || r_rr_b);
    w_exec    = (r_state == C_ST_EXEC);
    w_own_x   = r_win_b ? r_held_b[r_addr] : r_held_a[r_addr];
    w_own_y   = r_win_b ? r_held_a[r_addr] : r_held_b[r_addr];
    case (r_op)
      C_OP_REL: w_err = !w_own_x;
      default:  w_err = w_own_y;
    endcase
    w_rdata = ((r_op == C_OP_READ) && !w_err) ? r_mem[r_addr] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= C_ST_IDLE;
      r_rr_b    <= 1'b0;
      r_win_b   <= 1'b0;
      r_op      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_a_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_ack   <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
    end else begin
      r_a_ack   <= 1'b0;
      r_a_err   <= 1'b0;
      r_a_rdata <= '0;
      r_b_ack   <= 1'b0;
      r_b_err   <= 1'b0;
      r_b_rdata <= '0;
      case (r_state)
        C_ST_IDLE: begin
          if (a_req || b_req) begin
            r_win_b <= w_grant_b;
            r_rr_b  <= !w_grant_b;
            r_op    <= w_grant_b ? b_op    : a_op;
            r_addr  <= w_grant_b ? b_addr  : a_addr;
            r_wdata <= w_grant_b ? b_wdata : a_wdata;
            r_state <= C_ST_EXEC;
          end
        end
        C_ST_EXEC: begin
          if (r_win_b) begin
            r_b_ack   <= 1'b1;
            r_b_err   <= w_err;
            r_b_rdata <= w_rdata;
          end else begin
            r_a_ack   <= 1'b1;
            r_a_err   <= w_err;
            r_a_rdata <= w_rdata;
          end
          r_state <= C_ST_RESP;
        end
        C_ST_RESP: r_state <= C_ST_IDLE;
        default:   r_state <= C_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_mem[i] <= '0;
    end else if (w_exec && (r_op == C_OP_WRITE) && !w_err) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  // A successful owner access overrides an expiry landing on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_held_a <= '0;
      r_held_b <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((HOLD_TIMEOUT != 0) && (r_held_a[i] || r_held_b[i])) begin
          if (r_cnt[i] == C_CNT_LAST) begin
            r_held_a[i] <= 1'b0;
            r_held_b[i] <= 1'b0;
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
        if (w_exec && !w_err && (r_addr == ADDR_W'(i))) begin
          if (r_op == C_OP_REL) begin
            if (r_win_b) r_held_b[i] <= 1'b0;
            else         r_held_a[i] <= 1'b0;
            r_cnt[i] <= '0;
          end else if ((r_op == C_OP_HOLD) || w_own_x) begin
            if (r_win_b) r_held_b[i] <= 1'b1;
            else         r_held_a[i] <= 1'b1;
            r_cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign a_ack     = r_a_ack;
  assign a_err     = r_a_err;
  assign a_rdata   = r_a_rdata;
  assign b_ack     = r_b_ack;
  assign b_err     = r_b_err;
  assign b_rdata   = r_b_rdata;
  assign held_by_a = r_held_a;
  assign held_by_b = r_held_b;
  assign busy      = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_csm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_csm_arbiter
// Brief    : Self-checking bench for csm_arbiter: vector table, corner-case
//            sequences and randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_csm_arbiter;
  localparam int T = 16;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, HD = 2'b10, RL = 2'b11;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, b_req, a_ack, b_ack, a_err, b_err, busy;
  logic [1:0] a_op, b_op, a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [3:0] held_by_a, held_by_b;

  always #5 clk = ~clk;

  csm_arbiter #(.ADDR_W(2), .DATA_W(8), .HOLD_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .held_by_a(held_by_a), .held_by_b(held_by_b), .busy(busy)
  );

  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: owner 0 = free, 1 = A, 2 = B; a hold lives until its deadline cycle
  logic [7:0] m_mem [4];
  int         m_own [4];
  longint     m_dl  [4];
  bit         m_rr_b;

  function automatic void model_reset();
    for (int e = 0; e < 4; e++) begin
      m_mem[e] = 8'h00;
      m_own[e] = 0;
      m_dl[e]  = 0;
    end
    m_rr_b = 1'b0;
  endfunction

  function automatic bit m_held(input int e, input int who);
    return (m_own[e] == who) && (cyc < m_dl[e]);
  endfunction

  function automatic logic [3:0] m_vec(input int who);
    logic [3:0] v;
    for (int e = 0; e < 4; e++) v[e] = m_held(e, who);
    return v;
  endfunction

  function automatic void model_exec(input int x, input logic [1:0] op, input logic [1:0] ad,
                                     input logic [7:0] wd, input longint p,
                                     output bit e, output logic [7:0] r);
    int own;
    bit refresh;
    own = (m_own[ad] != 0 && p <= m_dl[ad]) ? m_own[ad] : 0;
    m_own[ad] = own;
    e = 1'b0;
    r = 8'h00;
    refresh = 1'b0;
    case (op)
      RD: if (own != 0 && own != x) e = 1'b1; else begin r = m_mem[ad]; refresh = (own == x); end
      WR: if (own != 0 && own != x) e = 1'b1; else begin m_mem[ad] = wd; refresh = (own == x); end
      HD: if (own != 0 && own != x) e = 1'b1; else begin m_own[ad] = x; refresh = 1'b1; end
      default: if (own == x) m_own[ad] = 0; else e = 1'b1;
    endcase
    if (refresh) m_dl[ad] = p + T;
    else if (m_own[ad] != 0 && p >= m_dl[ad]) m_own[ad] = 0;
    m_rr_b = (x == 1);
  endfunction

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, held_by_a, held_by_b, busy}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_req = 1'b0; a_op = RD; a_addr = 2'd0; a_wdata = 8'h00;
    b_req = 1'b0; b_op = RD; b_addr = 2'd0; b_wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk);
    #1;
  endtask

  // One arbitration round; caller is just after a rising edge with the DUT idle
  task automatic round(input bit ua, input logic [1:0] opa, input logic [1:0] ada, input logic [7:0] wda,
                       input bit ub, input logic [1:0] opb, input logic [1:0] adb, input logic [7:0] wdb,
                       output bit ea, output logic [7:0] ra, output bit eb, output logic [7:0] rb,
                       output logic [3:0] ha, output logic [3:0] hb);
    bit         pa, pb, first_b, me;
    logic [7:0] mr;
    int         n, slot_a, slot_b;
    first_b = ub && (!ua || m_rr_b);
    slot_a  = ua ? (first_b ? 6 : 3) : 0;
    slot_b  = ub ? (first_b ? 3 : 6) : 0;
    ea = 1'b0; ra = 8'h00; eb = 1'b0; rb = 8'h00; ha = 4'h0; hb = 4'h0;
    a_op = opa; a_addr = ada; a_wdata = wda; a_req = ua;
    b_op = opb; b_addr = adb; b_wdata = wdb; b_req = ub;
    pa = ua; pb = ub; n = 0;
    while ((pa || pb) && n < 12) begin
      @(negedge clk);
      n++;
      check("a_ack_timing", a_ack, (n == slot_a));
      check("b_ack_timing", b_ack, (n == slot_b));
      check("busy", busy, (n % 3) != 1);
      if (a_ack && pa) begin
        model_exec(1, opa, ada, wda, cyc, me, mr);
        check("a_err", a_err, me);
        check("a_rdata", a_rdata, mr);
        ea = a_err; ra = a_rdata; pa = 1'b0; a_req = 1'b0;
      end
      if (b_ack && pb) begin
        model_exec(2, opb, adb, wdb, cyc, me, mr);
        check("b_err", b_err, me);
        check("b_rdata", b_rdata, mr);
        eb = b_err; rb = b_rdata; pb = 1'b0; b_req = 1'b0;
      end
      if (!pa && !pb) begin
        ha = held_by_a; hb = held_by_b;
        check("held_by_a", held_by_a, m_vec(1));
        check("held_by_b", held_by_b, m_vec(2));
      end
    end
    check("ack_timeout", {pa, pb}, 2'b00);
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         port;
    logic [1:0] op;
    logic [1:0] addr;
    logic [7:0] wdata;
    bit         err;
    logic [7:0] rdata;
    logic [3:0] ha;
    logic [3:0] hb;
  } vec_t;

  localparam int NV = 22;
  vec_t       tbl [NV];
  bit         ea, eb;
  logic [7:0] ra, rb;
  logic [3:0] ha, hb;
  int         mode;

  initial begin
    tbl[0]  = '{1'b0, WR, 2'd1, 8'hA5, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, RD, 2'd1, 8'h00, 1'b0, 8'hA5, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, WR, 2'd2, 8'h11, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, HD, 2'd2, 8'h00, 1'b0, 8'h00, 4'b0100, 4'b0000};
    tbl[4]  = '{1'b1, RD, 2'd2, 8'h00, 1'b1, 8'h00, 4'b0100, 4'b0000};
    tbl[5]  = '{1'b1, WR, 2'd2, 8'h3C, 1'b1, 8'h00, 4'b0100, 4'b0000};
    tbl[6]  = '{1'b0, RD, 2'd2, 8'h00, 1'b0, 8'h11, 4'b0100, 4'b0000};
    tbl[7]  = '{1'b0, RL, 2'd2, 8'h00, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b0, HD, 2'd0, 8'h00, 1'b0, 8'h00, 4'b0001, 4'b0000};
    tbl[9]  = '{1'b0, RL, 2'd0, 8'h00, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[10] = '{1'b1, RD, 2'd0, 8'h00, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[11] = '{1'b1, RL, 2'd0, 8'h00, 1'b1, 8'h00, 4'b0000, 4'b0000};
    tbl[12] = '{1'b0, HD, 2'd0, 8'h00, 1'b0, 8'h00, 4'b0001, 4'b0000};
    tbl[13] = '{1'b0, HD, 2'd0, 8'h00, 1'b0, 8'h00, 4'b0001, 4'b0000};
    tbl[14] = '{1'b1, HD, 2'd0, 8'h00, 1'b1, 8'h00, 4'b0001, 4'b0000};
    tbl[15] = '{1'b0, RL, 2'd0, 8'h00, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[16] = '{1'b1, HD, 2'd3, 8'h00, 1'b0, 8'h00, 4'b0000, 4'b1000};
    tbl[17] = '{1'b0, WR, 2'd3, 8'h99, 1'b1, 8'h00, 4'b0000, 4'b1000};
    tbl[18] = '{1'b1, WR, 2'd3, 8'h42, 1'b0, 8'h00, 4'b0000, 4'b1000};
    tbl[19] = '{1'b1, RD, 2'd3, 8'h00, 1'b0, 8'h42, 4'b0000, 4'b1000};
    tbl[20] = '{1'b1, RL, 2'd3, 8'h00, 1'b0, 8'h00, 4'b0000, 4'b0000};
    tbl[21] = '{1'b0, RD, 2'd3, 8'h00, 1'b0, 8'h42, 4'b0000, 4'b0000};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      if (!tbl[i].port)
        round(1'b1, tbl[i].op, tbl[i].addr, tbl[i].wdata, 1'b0, RD, 2'd0, 8'h00, ea, ra, eb, rb, ha, hb);
      else
        round(1'b0, RD, 2'd0, 8'h00, 1'b1, tbl[i].op, tbl[i].addr, tbl[i].wdata, ea, ra, eb, rb, ha, hb);
      check($sformatf("vec%0d_err", i), tbl[i].port ? eb : ea, tbl[i].err);
      check($sformatf("vec%0d_rdata", i), tbl[i].port ? rb : ra, tbl[i].rdata);
      check($sformatf("vec%0d_held_a", i), ha, tbl[i].ha);
      check($sformatf("vec%0d_held_b", i), hb, tbl[i].hb);
    end

    // Simultaneous requests after reset; A keeps requesting, so the repeat tie goes to B
    do_reset();
    a_op = RD; a_addr = 2'd0; b_op = RD; b_addr = 2'd0;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      check($sformatf("tie_a_ack_c%0d", c), a_ack, (c == 2 || c == 8));
      check($sformatf("tie_b_ack_c%0d", c), b_ack, (c == 5));
      if (c == 5) b_req = 1'b0;
      if (c == 8) a_req = 1'b0;
    end
    @(posedge clk);
    #1;

    // Hold timeout: A's hold on entry 3 lapses after 16 idle cycles
    do_reset();
    round(1'b1, HD, 2'd3, 8'h00, 1'b0, RD, 2'd0, 8'h00, ea, ra, eb, rb, ha, hb);
    check("to_hold_granted", ha[3], 1'b1);
    idle(14);
    @(negedge clk);
    check("to_held_last_cycle", held_by_a[3], 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("to_held_expired", held_by_a[3], 1'b0);
    @(posedge clk);
    #1;
    round(1'b0, RD, 2'd0, 8'h00, 1'b1, HD, 2'd3, 8'h00, ea, ra, eb, rb, ha, hb);
    check("to_b_hold_err", eb, 1'b0);
    check("to_b_holds", hb[3], 1'b1);

    // Reset arriving while a write is executing drops it entirely
    do_reset();
    a_op = WR; a_addr = 2'd1; a_wdata = 8'h77; a_req = 1'b1;
    @(posedge clk);
    #1;
    check("rst_busy_exec", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_no_ack", a_ack, 1'b0);
    @(posedge clk);
    #1 a_req = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid_outputs");
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all_zero("rst_after_outputs");
    @(posedge clk);
    #1;
    round(1'b1, RD, 2'd1, 8'h00, 1'b0, RD, 2'd0, 8'h00, ea, ra, eb, rb, ha, hb);
    check("rst_mem_cleared", ra, 8'h00);

    // Randomized traffic, with occasional long gaps to let holds expire
    do_reset();
    for (int k = 0; k < 200; k++) begin
      mode = $urandom_range(0, 2);
      round(mode != 1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
            mode != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
            ea, ra, eb, rb, ha, hb);
      if ($urandom_range(0, 4) == 0) begin
        idle($urandom_range(10, 20));
        @(negedge clk);
        check("rand_idle_held_a", held_by_a, m_vec(1));
        check("rand_idle_held_b", held_by_b, m_vec(2));
        @(posedge clk);
        #1;
      end else begin
        idle($urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
